axi_rd_4k_split: RTL and testbench
==================================

Name: axi_rd_4k_split

Overview:
- Read-channel AXI4 burst splitter placed directly downstream of the streaming test block's virtual-memory master port.
- The streaming block issues read bursts of up to 64 × 64 B beats at arbitrary beat-aligned addresses. These bursts can cross 4 KiB page boundaries, which the memory system forbids.
- This block splits each slave AR into page-contained sub-bursts, forwards R data unchanged, and reasserts RLAST only at the end of the original burst.

Parameters:
- ADDR_W, 64, address width.
- ID_W, 16, AXI ID width.
- DATA_W, 512, data width (64 B beat).
- LOG_DEPTH, 4, log2 depth of the sub-burst tracking FIFO (maximum outstanding sub-bursts).

Ports:
- clk  in  1  user clock.
- rst  in  1  reset. Asynchronous, active-high.
- s_arid/s_araddr/s_arlen/s_arsize  in  ID_W/ADDR_W/8/3  slave AR request.
- s_arvalid  in  1;  s_arready  out  1.
- s_rid/s_rdata/s_rresp  out  ID_W/DATA_W/2  slave R beat.
- s_rlast  out  1;  s_rvalid  out  1;  s_rready  in  1.
- m_arid/m_araddr/m_arlen/m_arsize  out  ID_W/ADDR_W/8/3  master AR sub-burst.
- m_arvalid  out  1;  m_arready  in  1.
- m_rid/m_rdata/m_rresp/m_rlast/m_rvalid  in  ID_W/DATA_W/2/1/1  master R beat.
- m_rready  out  1.
- split_count  out  32  count of extra sub-bursts generated (total sub-bursts minus slave ARs).

Behaviour:
- Reset values: s_arready=0 during reset, then 1 in IDLE. m_arvalid=0, split_count=0, FIFO empty, state=IDLE. Reset acts asynchronously on all state.
- Beat size is fixed at 64 B. s_arsize is forwarded to m_arsize unchanged. s_araddr[5:0] must be 0; other values are unsupported.
- State IDLE:
  - s_arready=1.
  - On s_arvalid handshake: latch id, addr, size, and remaining beats = s_arlen+1 (9-bit, range 1..256). Go to ISSUE.
- State ISSUE:
  - s_arready=0.
  - page_beats = 64 − cur_addr[11:6].
  - sub_beats = min(remaining, page_beats).
  - m_araddr=cur_addr, m_arlen=sub_beats−1, m_arid=latched id.
  - m_arvalid = FIFO not full. Once asserted it stays stable until handshake, because the FIFO only drains while waiting.
  - On m_arvalid & m_arready:
    - Push last flag = (sub_beats == remaining) into the FIFO.
    - remaining −= sub_beats; cur_addr += sub_beats×64.
    - If last, go to IDLE. Otherwise increment split_count (wraps at 2^32).
- Latency: first m_arvalid appears no earlier than the cycle after the s_ar handshake. Sub-bursts are issued at up to one per cycle. A 256-beat burst produces at most 5 sub-bursts.
- R path is combinational pass-through:
  - s_rvalid=m_rvalid; m_rready=s_rready.
  - s_rid/s_rdata/s_rresp = m_* equivalents.
  - s_rlast = m_rlast & FIFO head last flag.
  - FIFO pops on m_rvalid & s_rready & m_rlast.
- Ordering: downstream returns R bursts in m_AR issue order across all IDs. The FIFO relies on this.
- FIFO boundaries:
  - Simultaneous push and pop is allowed; occupancy is unchanged.
  - At full, m_arvalid is held low until a pop occurs.
  - An R beat with FIFO empty is a protocol error. s_rlast is then forced to m_rlast.
- Error responses: rresp is forwarded per beat. Sub-burst SLVERR/DECERR are not merged.
- Reset mid-burst: all tracking is discarded. In-flight master R beats after reset are not supported. The environment must quiesce before reset.

Test Plan:
- s_araddr=0x1000, arlen=63 → one m_AR 0x1000 len 63. s_rlast on the 64th beat only. split_count=0.
- s_araddr=0x1FC0, arlen=1 → m_AR 0x1FC0 len 0, then 0x2000 len 0. First beat has m_rlast=1 and s_rlast=0; second beat has s_rlast=1. split_count=1.
- s_araddr=0x0800, arlen=255 → m_ARs at 0x0800 len 31, 0x1000 len 63, 0x2000 len 63, 0x3000 len 63, 0x4000 len 31. s_rlast on beat 256 only. split_count=4.
- LOG_DEPTH=2, m_arready=1, m_rvalid held 0, 4 page-crossing requests → m_arvalid low after 4 sub-bursts. Completing one R burst → next m_AR issues the following cycle with the same addr/len.
- s_rready toggled 0/1 every cycle during a 2-sub-burst read → m_rready mirrors s_rready. No beat is lost or duplicated, and the data sequence is intact.
- rst asserted mid-ISSUE (between clock edges) → m_arvalid=0 and split_count=0 immediately, FIFO empty. After release, s_arready=1 on the first clock.

Source files
------------

// File: rtl/axi_rd_4k_split.sv
// AXI4 read-channel burst splitter: breaks each slave AR into 4 KiB
// page-contained sub-bursts and rebuilds RLAST on the return path.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | waiting for a slave AR; s_arready high outside reset
//  S_ISSUE | issuing page-contained sub-bursts until the last one is accepted
module axi_rd_4k_split #(
  parameter int ADDR_W    = 64,
  parameter int ID_W      = 16,
  parameter int DATA_W    = 512,
  parameter int LOG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   s_arid,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic [7:0]        s_arlen,
  input  logic [2:0]        s_arsize,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [ID_W-1:0]   s_rid,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [ID_W-1:0]   m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [ID_W-1:0]   m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [31:0]       split_count
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  typedef enum logic [0:0] {S_IDLE, S_ISSUE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ID_W-1:0]      r_id;
  logic [ADDR_W-1:0]    r_addr;
  logic [2:0]           r_size;
  logic [8:0]           r_rem;
  logic [31:0]          r_split_count;
  logic [DEPTH-1:0]     r_fifo;
  logic [LOG_DEPTH-1:0] r_wr_ptr;
  logic [LOG_DEPTH-1:0] r_rd_ptr;
  logic [LOG_DEPTH:0]   r_count;

  logic [6:0] w_page_beats;
  logic [8:0] w_sub_beats;
  logic       w_sub_last;
  logic       w_full;
  logic       w_empty;
  logic       w_ar_hs;
  logic       w_push;
  logic       w_pop;

  // Beats left in the current 4 KiB page bound the next sub-burst.
  assign w_page_beats = 7'd64 - {1'b0, r_addr[11:6]};
  assign w_sub_beats  = ({2'b00, w_page_beats} < r_rem) ? {2'b00, w_page_beats} : r_rem;
  assign w_sub_last   = (w_sub_beats == r_rem);
  assign w_full       = (r_count == (LOG_DEPTH+1)'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_ar_hs      = s_arvalid & s_arready;
  assign w_push       = m_arvalid & m_arready;
  assign w_pop        = m_rvalid & s_rready & m_rlast & ~w_empty;

  assign m_arid      = r_id;
  assign m_araddr    = r_addr;
  assign m_arsize    = r_size;
  assign m_arlen     = 8'(w_sub_beats - 9'd1);
  assign split_count = r_split_count;

  // R data passes straight through; only RLAST is qualified by the tracker.
  assign s_rvalid = m_rvalid;
  assign m_rready = s_rready;
  assign s_rid    = m_rid;
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rlast  = m_rlast & (w_empty | r_fifo[r_rd_ptr]);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs; s_arready is held low while in reset.
  always_comb begin
    w_state_nxt = r_state;
    s_arready   = 1'b0;
    m_arvalid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        s_arready = ~rst;
        if (s_arvalid && !rst) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        m_arvalid = ~w_full;
        if (!w_full && m_arready && w_sub_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request context: latch on slave AR, advance on each accepted sub-burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id          <= '0;
      r_addr        <= '0;
      r_size        <= '0;
      r_rem         <= '0;
      r_split_count <= '0;
    end else if (w_ar_hs) begin
      r_id   <= s_arid;
      r_addr <= s_araddr;
      r_size <= s_arsize;
      r_rem  <= {1'b0, s_arlen} + 9'd1;
    end else if (w_push) begin
      r_rem  <= r_rem - w_sub_beats;
      r_addr <= r_addr + ADDR_W'({w_sub_beats, 6'b0});
      if (!w_sub_last) r_split_count <= r_split_count + 32'd1;
    end
  end

  // Last-flag tracker: one entry per outstanding sub-burst, in issue order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fifo   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_sub_last;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_4k_split.sv
// Bench for axi_rd_4k_split: scoreboard of expected sub-burst ARs and
// slave R beats, filled when a slave AR is driven and drained by monitors.
module tb_axi_rd_4k_split;

  localparam int AW = 64;
  localparam int IW = 16;
  localparam int DW = 512;
  localparam int LD = 2;

  logic          clk, rst;
  logic [IW-1:0] s_arid;
  logic [AW-1:0] s_araddr;
  logic [7:0]    s_arlen;
  logic [2:0]    s_arsize;
  logic          s_arvalid, s_arready;
  logic [IW-1:0] s_rid;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rlast, s_rvalid, s_rready;
  logic [IW-1:0] m_arid;
  logic [AW-1:0] m_araddr;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic          m_arvalid, m_arready;
  logic [IW-1:0] m_rid;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rlast, m_rvalid, m_rready;
  logic [31:0]   split_count;

  axi_rd_4k_split #(.ADDR_W(AW), .ID_W(IW), .DATA_W(DW), .LOG_DEPTH(LD)) dut (
    .clk(clk), .rst(rst),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .split_count(split_count)
  );

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [15:0] id;
  } ar_t;

  typedef struct {
    logic [63:0] val;
    logic        last;
    logic [15:0] id;
    logic [1:0]  resp;
  } r_t;

  ar_t exp_ar[$];
  ar_t rec_ar[$];
  r_t  exp_r[$];
  int  errors = 0;
  int  checks = 0;
  int  exp_split = 0;
  logic tog_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] beat_data(input logic [63:0] a);
    return {8{a}};
  endfunction

  // Monitors: sampled on the falling edge, a handshake seen here completes
  // on the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (m_rready !== s_rready) begin
        errors++;
        $display("FAIL rready_mirror: m_rready=%b required %b", m_rready, s_rready);
      end
      if (m_arvalid && m_arready) begin
        ar_t got;
        got.addr = m_araddr; got.len = m_arlen; got.id = m_arid;
        rec_ar.push_back(got);
        checks++;
        if (exp_ar.size() == 0) begin
          errors++;
          $display("FAIL m_ar_unexpected: addr=%h len=%0d with none expected", m_araddr, m_arlen);
        end else begin
          ar_t e;
          e = exp_ar.pop_front();
          if (m_araddr !== e.addr || m_arlen !== e.len || m_arid !== e.id || m_arsize !== 3'd6) begin
            errors++;
            $display("FAIL m_ar: addr=%h len=%0d id=%h size=%0d required addr=%h len=%0d id=%h size=6",
                     m_araddr, m_arlen, m_arid, m_arsize, e.addr, e.len, e.id);
          end
        end
      end
      if (s_rvalid && s_rready) begin
        checks++;
        if (exp_r.size() == 0) begin
          errors++;
          $display("FAIL s_r_unexpected: data=%h last=%b with none expected", s_rdata[63:0], s_rlast);
        end else begin
          r_t e;
          e = exp_r.pop_front();
          if (s_rdata !== beat_data(e.val) || s_rlast !== e.last || s_rid !== e.id || s_rresp !== e.resp) begin
            errors++;
            $display("FAIL s_r: data=%h last=%b id=%h resp=%0d required data=%h last=%b id=%h resp=%0d",
                     s_rdata[63:0], s_rlast, s_rid, s_rresp, e.val, e.last, e.id, e.resp);
          end
        end
      end
    end
  end

  // Reference split: walk the burst beat by beat, closing a sub-burst at
  // each page boundary and at the end of the burst.
  task automatic model_push(input logic [63:0] addr, input logic [7:0] len, input logic [15:0] id);
    int beats = int'(len) + 1;
    int cnt = 0;
    logic [63:0] a = addr;
    logic [63:0] start = addr;
    for (int i = 0; i < beats; i++) begin
      r_t r;
      ar_t s;
      r.val = a; r.last = (i == beats - 1); r.id = id; r.resp = a[7:6];
      exp_r.push_back(r);
      cnt++;
      a = a + 64'd64;
      if (i == beats - 1 || a[11:0] == 12'h000) begin
        s.addr = start; s.len = 8'(cnt - 1); s.id = id;
        exp_ar.push_back(s);
        if (i != beats - 1) exp_split++;
        start = a;
        cnt = 0;
      end
    end
  endtask

  task automatic send_ar(input logic [63:0] addr, input logic [7:0] len, input logic [15:0] id);
    logic got = 1'b0;
    model_push(addr, len, id);
    s_arvalid = 1'b1; s_araddr = addr; s_arlen = len; s_arid = id; s_arsize = 3'd6;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk); got = s_arready;
      @(posedge clk); #1;
    end
    s_arvalid = 1'b0;
    if (!got) begin
      errors++; checks++;
      $display("FAIL s_ar_timeout: s_arready=0 required 1 within 200 cycles");
    end
  endtask

  task automatic respond(input int n);
    for (int b = 0; b < n; b++) begin
      ar_t ar;
      int c = 0;
      while (rec_ar.size() == 0 && c < 200) begin
        @(negedge clk); @(posedge clk); #1; c++;
      end
      if (rec_ar.size() == 0) begin
        errors++; checks++;
        $display("FAIL r_no_ar: outstanding=0 required 1 within 200 cycles");
        return;
      end
      ar = rec_ar.pop_front();
      for (int j = 0; j <= int'(ar.len); j++) begin
        logic [63:0] a = ar.addr + 64'(j * 64);
        logic hs = 1'b0;
        m_rvalid = 1'b1; m_rid = ar.id; m_rdata = beat_data(a); m_rresp = a[7:6];
        m_rlast = (j == int'(ar.len));
        for (int k = 0; k < 200 && !hs; k++) begin
          @(negedge clk); hs = m_rready;
          @(posedge clk); #1;
        end
        if (!hs) begin
          errors++; checks++;
          $display("FAIL r_timeout: m_rready=0 required 1 within 200 cycles");
        end
      end
      m_rvalid = 1'b0; m_rlast = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((exp_r.size() != 0 || exp_ar.size() != 0) && c < 3000) begin
      @(posedge clk); #1; c++;
    end
    checks++;
    if (exp_r.size() != 0 || exp_ar.size() != 0) begin
      errors++;
      $display("FAIL drain: pending r=%0d ar=%0d required 0/0", exp_r.size(), exp_ar.size());
    end
  endtask

  task automatic check_split(input string name);
    @(negedge clk);
    checks++;
    if (split_count !== 32'(exp_split)) begin
      errors++;
      $display("FAIL %s: split_count=%0d required %0d", name, split_count, exp_split);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_arvalid = 0; s_arid = 0; s_araddr = 0; s_arlen = 0; s_arsize = 0; s_rready = 1'b1;
    m_arready = 1'b1; m_rvalid = 0; m_rid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0;
    #12;
    checks++;
    if (s_arready !== 1'b0 || m_arvalid !== 1'b0 || split_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_vals: arready=%b arvalid=%b split=%0d required 0/0/0", s_arready, m_arvalid, split_count);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_arready !== 1'b1) begin
      errors++;
      $display("FAIL idle_arready: s_arready=%b required 1", s_arready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    send_ar(64'h1000, 8'd63, 16'h0011);
    respond(1);
    wait_drain();
    check_split("split_single");
  endtask

  task automatic test_cross();
    send_ar(64'h1FC0, 8'd1, 16'h0022);
    respond(2);
    wait_drain();
    check_split("split_cross");
  endtask

  task automatic test_big();
    fork
      send_ar(64'h0800, 8'd255, 16'h0033);
      respond(5);
    join
    wait_drain();
    check_split("split_big");
  endtask

  task automatic test_full();
    send_ar(64'h1FC0, 8'd1, 16'h0041);
    send_ar(64'h2FC0, 8'd1, 16'h0042);
    send_ar(64'h1FC0, 8'd1, 16'h0043);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (m_arvalid !== 1'b0) begin
        errors++;
        $display("FAIL full_hold: m_arvalid=%b required 0", m_arvalid);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (rec_ar.size() != 4) begin
      errors++;
      $display("FAIL full_count: issued=%0d required 4", rec_ar.size());
    end
    respond(1);
    @(negedge clk);
    checks++;
    if (m_arvalid !== 1'b1 || m_araddr !== 64'h1FC0 || m_arlen !== 8'd0) begin
      errors++;
      $display("FAIL full_release: arvalid=%b addr=%h len=%0d required 1/1fc0/0", m_arvalid, m_araddr, m_arlen);
    end
    @(posedge clk); #1;
    fork
      send_ar(64'h3FC0, 8'd1, 16'h0044);
      respond(7);
    join
    wait_drain();
    check_split("split_full");
  endtask

  task automatic test_rready_toggle();
    tog_done = 1'b0;
    fork
      begin
        send_ar(64'h2FC0, 8'd3, 16'h0055);
        respond(2);
        tog_done = 1'b1;
      end
      while (!tog_done) begin
        @(posedge clk); #1;
        s_rready = ~s_rready;
      end
    join
    s_rready = 1'b1;
    wait_drain();
    check_split("split_toggle");
  endtask

  task automatic test_reset_mid();
    m_arready = 1'b0;
    send_ar(64'h0800, 8'd255, 16'h0066);
    m_arready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_arready = 1'b0;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if (m_arvalid !== 1'b0 || split_count !== 32'd0 || s_arready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: arvalid=%b split=%0d arready=%b required 0/0/0", m_arvalid, split_count, s_arready);
    end
    s_rready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b1;
    #1;
    checks++;
    if (s_rlast !== 1'b1) begin
      errors++;
      $display("FAIL reset_fifo_empty: s_rlast=%b required 1", s_rlast);
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 1'b1; m_arready = 1'b1;
    exp_ar.delete(); exp_r.delete(); rec_ar.delete();
    exp_split = 0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_arready !== 1'b1 || m_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: arready=%b arvalid=%b required 1/0", s_arready, m_arvalid);
    end
    @(posedge clk); #1;
    send_ar(64'h1FC0, 8'd1, 16'h0077);
    respond(2);
    wait_drain();
    check_split("split_after_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_cross();
    test_big();
    test_full();
    test_rready_toggle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
